// File: rtl/rram_pulse_ctrl.sv
// rram_pulse_ctrl
// ---------------------------------------------------------------------------
// Pulse sequencer for an RRAM 1T1R test structure. It takes one
// FORM / SET / RESET / READ command at a time and walks it through these
// phases: SETUP (selects only), PULSE (one drive), HOLD (selects only), DONE
// (one-cycle response). Every wordline, source-line and drive enable is
// decoded from the FSM state, so a reset clears them at the next edge.
//
// Optional feature (compile macro RRAM_VERIFY_EN): after the HOLD of a write,
// the FSM runs a verify read (VSETUP / VREAD / VHOLD). The sense value sampled
// at the end of VREAD becomes the response data.
//
// Ports
//   wb_clk_i   in   clock
//   wb_rst_i   in   synchronous active-high reset
//   cmd_valid  in   command request
//   cmd_ready  out  high only in IDLE
//   cmd_op     in   2  00 READ, 01 SET, 10 RESET, 11 FORM
//   cmd_row    in   1  wordline select (0 -> WL0, 1 -> WL1)
//   cmd_col    in   2  source-line device index
//   cmd_width  in   PW_W  pulse width in cycles (0 is treated as 1)
//   sense_in   in   sense comparator (1 = low resistance)
//   wl_en      out  2  one-hot wordline enable
//   sl_sel     out  4  one-hot source-line select
//   te_drive   out  top-electrode drive (SET, FORM)
//   sl_drive   out  source-line drive (RESET)
//   read_en    out  read bias enable
//   busy       out  high whenever the FSM is not IDLE
//   rsp_valid  out  one-cycle response strobe
//   rsp_data   out  sampled sense value, held until the next DONE
// ---------------------------------------------------------------------------
module rram_pulse_ctrl #(
  parameter int PW_W      = 16,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int READ_CYC  = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic            cmd_row,
  input  logic [1:0]      cmd_col,
  input  logic [PW_W-1:0] cmd_width,
  input  logic            sense_in,
  output logic [1:0]      wl_en,
  output logic [3:0]      sl_sel,
  output logic            te_drive,
  output logic            sl_drive,
  output logic            read_en,
  output logic            busy,
  output logic            rsp_valid,
  output logic            rsp_data
);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_FORM  = 2'b11
  } op_e;

`ifdef RRAM_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_VSETUP, S_VREAD, S_VHOLD, S_DONE
  } state_e;
  localparam logic [PW_W-1:0] READ_LOAD  = PW_W'(READ_CYC - 1);
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE
  } state_e;
`endif

  // Each phase counter is loaded with (length - 1) and the phase ends when
  // the counter reads zero. One PW_W-bit down-counter serves every phase.
  localparam logic [PW_W-1:0] SETUP_LOAD = PW_W'(SETUP_CYC - 1);
  localparam logic [PW_W-1:0] HOLD_LOAD  = PW_W'(HOLD_CYC - 1);
  localparam logic [PW_W-1:0] ONE        = PW_W'(1);

  if (SETUP_CYC < 1 || HOLD_CYC < 1 || READ_CYC < 1) begin : g_bad_param
    $error("rram_pulse_ctrl: SETUP_CYC, HOLD_CYC and READ_CYC must be >= 1");
  end

  state_e          state, state_d;
  logic [PW_W-1:0] cnt, cnt_d;
  op_e             op_q;
  logic            row_q;
  logic [1:0]      col_q;
  logic [PW_W-1:0] width_q;
  logic            sense_q;
  logic            rsp_next;

  logic            accept;
  logic            sample;
  logic            enter_done;
  logic            sel_on;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= OP_READ;
      row_q    <= 1'b0;
      col_q    <= 2'b00;
      width_q  <= ONE;
      sense_q  <= 1'b0;
      rsp_data <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        op_q    <= op_e'(cmd_op);
        row_q   <= cmd_row;
        col_q   <= cmd_col;
        width_q <= (cmd_width == '0) ? ONE : cmd_width;
      end
      if (sample) begin
        sense_q <= sense_in;
      end
      if (enter_done) begin
        rsp_data <= rsp_next;
      end
    end
  end

`ifdef RRAM_VERIFY_EN
  // Reads report their pulse sample. Writes report their verify sample.
  // Both values land in sense_q.
  assign rsp_next = sense_q;
`else
  assign rsp_next = (op_q == OP_READ) ? sense_q : 1'b0;
`endif

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    accept     = 1'b0;
    sample     = 1'b0;
    enter_done = 1'b0;
    sel_on     = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    te_drive   = 1'b0;
    sl_drive   = 1'b0;
    read_en    = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end

      S_SETUP: begin
        sel_on = 1'b1;
        if (cnt == '0) begin
          state_d = S_PULSE;
          cnt_d   = width_q - ONE;
        end else begin
          cnt_d = cnt - ONE;
        end
      end

      S_PULSE: begin
        sel_on = 1'b1;
        case (op_q)
          OP_READ:  read_en  = 1'b1;
          OP_RESET: sl_drive = 1'b1;
          default:  te_drive = 1'b1;
        endcase
        if (cnt == '0) begin
          // The sense comparator is sampled on the last pulse cycle of a read.
          sample  = (op_q == OP_READ);
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt - ONE;
        end
      end

      S_HOLD: begin
        sel_on = 1'b1;
        if (cnt == '0) begin
`ifdef RRAM_VERIFY_EN
          if (op_q != OP_READ) begin
            state_d = S_VSETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end
`else
          state_d    = S_DONE;
          enter_done = 1'b1;
`endif
        end else begin
          cnt_d = cnt - ONE;
        end
      end

`ifdef RRAM_VERIFY_EN
      S_VSETUP: begin
        sel_on = 1'b1;
        if (cnt == '0) begin
          state_d = S_VREAD;
          cnt_d   = READ_LOAD;
        end else begin
          cnt_d = cnt - ONE;
        end
      end

      S_VREAD: begin
        sel_on  = 1'b1;
        read_en = 1'b1;
        if (cnt == '0) begin
          sample  = 1'b1;
          state_d = S_VHOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt - ONE;
        end
      end

      S_VHOLD: begin
        sel_on = 1'b1;
        if (cnt == '0) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
`endif

      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The selects come from registered fields and sel_on is flat over
  // SETUP..HOLD. They therefore cannot move while a drive is active.
  assign wl_en  = sel_on ? (2'b01 << row_q)   : 2'b00;
  assign sl_sel = sel_on ? (4'b0001 << col_q) : 4'b0000;

endmodule
